// File: rtl/am25ls_modcnt.sv
// Up/down modulo counter with sync clear, parallel load, split count enables,
// terminal-count flag, cascadable ripple carry and a sticky wrap flag.
module am25ls_modcnt #(
    parameter int WIDTH     = 8,
    parameter bit MODULO_EN = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] in,
    input  logic             load_,
    input  logic             ent_,
    input  logic             enp_,
    input  logic             ud,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] q,
    output logic             mxmn,
    output logic             rco_,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             wrap_d;
    logic             wrap_q;
    logic             at_top;
    logic             at_zero;

    // Binary mode terminates at all-ones; lim is then don't-care.
    assign top     = MODULO_EN ? lim : {WIDTH{1'b1}};
    // Values above top count as terminal so an out-of-range load wraps at once.
    assign at_top  = (q_q >= top);
    assign at_zero = (q_q == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = wrap_q;
        if (!load_) begin
            q_d    = in;
            wrap_d = 1'b0;
        end else if (!ent_ && !enp_) begin
            if (!ud) begin
                if (at_top) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    q_d    = top;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // Purely combinational so ud/lim/ent_ changes show up in the same cycle.
    assign mxmn = (!ud && at_top) || (ud && at_zero);
    assign rco_ = !(mxmn && !ent_);
    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_am25ls_modcnt.sv
// Testbench for am25ls_modcnt: directed vector table, cascade sequence,
// combinational-path checks and randomized run against a behavioural model.
module tb_am25ls_modcnt;

    logic       clk = 1'b0;
    logic       clr, load_, ent_, enp_, ud;
    logic [3:0] din, lim;

    logic [3:0] m_q, b_q;
    logic       m_mxmn, m_rco_, m_wrap;
    logic       b_mxmn, b_rco_, b_wrap;

    logic       c_clr, c_load_, c_ent_, c_enp_, c_ud;
    logic [7:0] c_in;
    logic [3:0] c_lim;
    logic [3:0] lo_q, hi_q;
    logic       lo_mxmn, hi_mxmn, lo_rco_, hi_rco_, lo_wrap, hi_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    am25ls_modcnt #(.WIDTH(4), .MODULO_EN(1'b1)) u_mod (
        .clk(clk), .clr(clr), .in(din), .load_(load_), .ent_(ent_), .enp_(enp_),
        .ud(ud), .lim(lim), .q(m_q), .mxmn(m_mxmn), .rco_(m_rco_), .wrap(m_wrap)
    );

    am25ls_modcnt #(.WIDTH(4), .MODULO_EN(1'b0)) u_bin (
        .clk(clk), .clr(clr), .in(din), .load_(load_), .ent_(ent_), .enp_(enp_),
        .ud(ud), .lim(lim), .q(b_q), .mxmn(b_mxmn), .rco_(b_rco_), .wrap(b_wrap)
    );

    am25ls_modcnt #(.WIDTH(4), .MODULO_EN(1'b0)) u_lo (
        .clk(clk), .clr(c_clr), .in(c_in[3:0]), .load_(c_load_), .ent_(c_ent_), .enp_(c_enp_),
        .ud(c_ud), .lim(c_lim), .q(lo_q), .mxmn(lo_mxmn), .rco_(lo_rco_), .wrap(lo_wrap)
    );

    am25ls_modcnt #(.WIDTH(4), .MODULO_EN(1'b0)) u_hi (
        .clk(clk), .clr(c_clr), .in(c_in[7:4]), .load_(c_load_), .ent_(lo_rco_), .enp_(c_enp_),
        .ud(c_ud), .lim(c_lim), .q(hi_q), .mxmn(hi_mxmn), .rco_(hi_rco_), .wrap(hi_wrap)
    );

    typedef struct {
        logic       sel;   // 0 = modulo instance, 1 = binary instance
        logic       clr, load_, ent_, enp_, ud;
        logic [3:0] din, lim;
        logic [3:0] q;
        logic       mxmn, rco_, wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic sel, input logic c, input logic ld, input logic et,
                        input logic ep, input logic u, input logic [3:0] d, input logic [3:0] l,
                        input logic [3:0] eq, input logic emx, input logic erc, input logic ewr);
        vec_t v;
        v.sel = sel; v.clr = c; v.load_ = ld; v.ent_ = et; v.enp_ = ep; v.ud = u;
        v.din = d; v.lim = l; v.q = eq; v.mxmn = emx; v.rco_ = erc; v.wrap = ewr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int mq, mw, bq, bw;
    logic exp_mx, exp_rc;

    initial begin
        clr = 1'b0; load_ = 1'b1; ent_ = 1'b1; enp_ = 1'b1; ud = 1'b0; din = '0; lim = 4'd9;
        c_clr = 1'b0; c_load_ = 1'b1; c_ent_ = 1'b1; c_enp_ = 1'b1; c_ud = 1'b0; c_in = '0; c_lim = '0;

        //   sel clr ld et ep ud din lim   q mx rc wr
        // binary wrap from 13
        addv(1, 1, 1, 0, 0, 0,  0, 9,   0, 0, 1, 0);
        addv(1, 0, 0, 0, 0, 0, 13, 9,  13, 0, 1, 0);
        addv(1, 0, 1, 0, 0, 0,  0, 9,  14, 0, 1, 0);
        addv(1, 0, 1, 0, 0, 0,  0, 9,  15, 1, 0, 0);
        addv(1, 0, 1, 0, 0, 0,  0, 9,   0, 0, 1, 1);
        addv(1, 0, 1, 0, 0, 0,  0, 9,   1, 0, 1, 1);
        // reset state seen with ud=1, ent_=0
        addv(0, 1, 1, 0, 0, 1,  0, 9,   0, 1, 0, 0);
        // modulo-10 up then down
        addv(0, 0, 0, 0, 0, 0,  7, 9,   7, 0, 1, 0);
        addv(0, 0, 1, 0, 0, 0,  0, 9,   8, 0, 1, 0);
        addv(0, 0, 1, 0, 0, 0,  0, 9,   9, 1, 0, 0);
        addv(0, 0, 1, 0, 0, 0,  0, 9,   0, 0, 1, 1);
        addv(0, 0, 1, 0, 0, 0,  0, 9,   1, 0, 1, 1);
        addv(0, 0, 1, 0, 0, 1,  0, 9,   0, 1, 0, 1);
        addv(0, 0, 1, 0, 0, 1,  0, 9,   9, 0, 1, 1);
        // enable split at terminal 15
        addv(1, 0, 0, 0, 0, 0, 15, 9,  15, 1, 0, 0);
        addv(1, 0, 1, 0, 1, 0,  0, 9,  15, 1, 0, 0);
        addv(1, 0, 1, 1, 0, 0,  0, 9,  15, 1, 1, 0);
        // clr beats load, then load
        addv(0, 1, 0, 0, 0, 0,  5, 9,   0, 0, 1, 0);
        addv(0, 0, 0, 0, 0, 0,  5, 9,   5, 0, 1, 0);
        // out-of-range above lim
        addv(0, 0, 0, 0, 0, 0, 12, 9,  12, 1, 0, 0);
        addv(0, 0, 1, 0, 0, 0,  0, 9,   0, 0, 1, 1);
        addv(0, 0, 0, 0, 0, 1, 12, 9,  12, 0, 1, 0);
        addv(0, 0, 1, 0, 0, 1,  0, 9,  11, 0, 1, 0);
        // lim==0 holds at zero
        addv(0, 0, 0, 0, 0, 0,  3, 0,   3, 1, 0, 0);
        addv(0, 0, 1, 0, 0, 0,  0, 0,   0, 1, 0, 1);
        addv(0, 0, 0, 0, 0, 1,  0, 0,   0, 1, 0, 0);
        addv(0, 0, 1, 0, 0, 1,  0, 0,   0, 1, 0, 1);
        // clr aborts a count, then counting resumes from 0
        addv(0, 0, 0, 0, 0, 0,  4, 9,   4, 0, 1, 0);
        addv(0, 1, 1, 0, 0, 0,  0, 9,   0, 0, 1, 0);
        addv(0, 0, 1, 0, 0, 0,  0, 9,   1, 0, 1, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            clr = vecs[i].clr; load_ = vecs[i].load_; ent_ = vecs[i].ent_;
            enp_ = vecs[i].enp_; ud = vecs[i].ud; din = vecs[i].din; lim = vecs[i].lim;
            @(posedge clk); #1;
            if (vecs[i].sel) begin
                chk($sformatf("vec%0d_bin_q", i), 32'(b_q), 32'(vecs[i].q));
                chk($sformatf("vec%0d_bin_mxmn", i), 32'(b_mxmn), 32'(vecs[i].mxmn));
                chk($sformatf("vec%0d_bin_rco", i), 32'(b_rco_), 32'(vecs[i].rco_));
                chk($sformatf("vec%0d_bin_wrap", i), 32'(b_wrap), 32'(vecs[i].wrap));
                $display("vec %0d bin q=%0d mxmn=%b rco_=%b wrap=%b", i, b_q, b_mxmn, b_rco_, b_wrap);
            end else begin
                chk($sformatf("vec%0d_mod_q", i), 32'(m_q), 32'(vecs[i].q));
                chk($sformatf("vec%0d_mod_mxmn", i), 32'(m_mxmn), 32'(vecs[i].mxmn));
                chk($sformatf("vec%0d_mod_rco", i), 32'(m_rco_), 32'(vecs[i].rco_));
                chk($sformatf("vec%0d_mod_wrap", i), 32'(m_wrap), 32'(vecs[i].wrap));
                $display("vec %0d mod q=%0d mxmn=%b rco_=%b wrap=%b", i, m_q, m_mxmn, m_rco_, m_wrap);
            end
        end

        // Same-cycle response of mxmn/rco_ to ent_, lim, ud (no clock edge)
        clr = 0; load_ = 0; din = 4'd9; lim = 4'd9; ud = 0; ent_ = 1; enp_ = 1;
        @(posedge clk); #1;
        load_ = 1;
        #1; chk("comb_ent_hi_rco", 32'(m_rco_), 32'd1);
        chk("comb_mxmn_at_lim", 32'(m_mxmn), 32'd1);
        ent_ = 0; #1; chk("comb_ent_lo_rco", 32'(m_rco_), 32'd0);
        lim = 4'd10; #1; chk("comb_lim_mxmn", 32'(m_mxmn), 32'd0);
        chk("comb_lim_rco", 32'(m_rco_), 32'd1);
        lim = 4'd9; ud = 1; #1; chk("comb_ud_mxmn", 32'(m_mxmn), 32'd0);
        $display("comb q=%0d mxmn=%b rco_=%b", m_q, m_mxmn, m_rco_);
        ent_ = 1;

        // Two-stage cascade from 0x0E
        @(negedge clk);
        c_load_ = 0; c_in = 8'h0E; c_ent_ = 0; c_enp_ = 0; c_ud = 0;
        @(posedge clk); #1;
        chk("casc_load", 32'({hi_q, lo_q}), 32'h0E);
        chk("casc_load_rco", 32'(lo_rco_), 32'd1);
        $display("casc q=%02h lo_rco_=%b", {hi_q, lo_q}, lo_rco_);
        c_load_ = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("casc_q%0d", k), 32'({hi_q, lo_q}), 32'h0F + 32'(k));
            chk($sformatf("casc_rco%0d", k), 32'(lo_rco_), (k == 0) ? 32'd0 : 32'd1);
            $display("casc q=%02h lo_rco_=%b", {hi_q, lo_q}, lo_rco_);
        end

        // Randomized run against behavioural model
        mq = 0; mw = 0; bq = 0; bw = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            clr   = (i == 0) || ($urandom_range(0, 19) == 0);
            load_ = ($urandom_range(0, 7) != 0);
            ent_  = ($urandom_range(0, 3) == 0);
            enp_  = ($urandom_range(0, 3) == 0);
            ud    = 1'($urandom_range(0, 1));
            din   = 4'($urandom_range(0, 15));
            lim   = 4'($urandom_range(0, 15));
            if (clr) begin
                mq = 0; mw = 0; bq = 0; bw = 0;
            end else if (!load_) begin
                mq = int'(din); mw = 0; bq = int'(din); bw = 0;
            end else if (!ent_ && !enp_) begin
                if (!ud) begin
                    if (mq >= int'(lim)) begin mq = 0; mw = 1; end
                    else mq = mq + 1;
                    if (bq == 15) bw = 1;
                    bq = (bq + 1) % 16;
                end else begin
                    if (mq == 0) begin mq = int'(lim); mw = 1; end
                    else mq = mq - 1;
                    if (bq == 0) bw = 1;
                    bq = (bq + 15) % 16;
                end
            end
            @(posedge clk); #1;
            exp_mx = ud ? (mq == 0) : (mq >= int'(lim));
            exp_rc = !(exp_mx && !ent_);
            chk("rnd_mod_q", 32'(m_q), 32'(mq));
            chk("rnd_mod_wrap", 32'(m_wrap), 32'(mw));
            chk("rnd_mod_mxmn", 32'(m_mxmn), 32'(exp_mx));
            chk("rnd_mod_rco", 32'(m_rco_), 32'(exp_rc));
            exp_mx = ud ? (bq == 0) : (bq == 15);
            exp_rc = !(exp_mx && !ent_);
            chk("rnd_bin_q", 32'(b_q), 32'(bq));
            chk("rnd_bin_wrap", 32'(b_wrap), 32'(bw));
            chk("rnd_bin_mxmn", 32'(b_mxmn), 32'(exp_mx));
            chk("rnd_bin_rco", 32'(b_rco_), 32'(exp_rc));
            $display("rnd %0d mod q=%0d/%0d bin q=%0d/%0d", i, m_q, mq, b_q, bq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/am25ls_modcnt.md
AM25LS_MODCNT -- requirements
Module: am25ls_modcnt

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 SHALL have parameter MODULO_EN, default 1; when 0, the lim port is ignored and the terminal value is 2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port in, input, WIDTH bits: parallel load data.
REQ-006 SHALL have port load_, input, 1 bit: active-low synchronous parallel load.
REQ-007 SHALL have port ent_, input, 1 bit: active-low count enable, also gates rco_.
REQ-008 SHALL have port enp_, input, 1 bit: active-low count enable, does not gate rco_.
REQ-009 SHALL have port ud, input, 1 bit: 0 = count up, 1 = count down.
REQ-010 SHALL have port lim, input, WIDTH bits: terminal value (top) in modulo mode.
REQ-011 SHALL have port q, output, WIDTH bits: counter state.
REQ-012 SHALL have port mxmn, output, 1 bit: terminal-count indicator, active-high.
REQ-013 SHALL have port rco_, output, 1 bit: active-low ripple carry/borrow out for cascading.
REQ-014 SHALL have port wrap, output, 1 bit: sticky flag, set once the counter has wrapped.

Function
REQ-015 SHALL define top = lim when MODULO_EN=1, else top = 2^WIDTH-1.
REQ-016 SHALL give edge priority, highest first: clr, then load_=0, then count, then hold.
REQ-017 SHALL, on load_=0, set q <= in regardless of ent_, enp_, ud and top, and clear wrap.
REQ-018 SHALL count only when load_=1 and ent_=0 and enp_=0; otherwise q and wrap hold.
REQ-019 SHALL, counting up: q==top or q>top -> q <= 0 with wrap <= 1; else q <= q+1.
REQ-020 SHALL, counting down: q==0 -> q <= top with wrap <= 1; else q <= q-1 (q>top decrements normally).
REQ-021 SHALL compute all arithmetic modulo 2^WIDTH; no carry escapes q.
REQ-022 SHALL drive mxmn combinationally = (ud==0 and q>=top) or (ud==1 and q==0), independent of the enables.
REQ-023 SHALL drive rco_ combinationally = NOT(mxmn AND NOT ent_), giving one low cycle per terminal state while enabled.
REQ-024 SHALL reflect a change on ud, lim or ent_ in mxmn/rco_ within the same cycle, with no register delay.
REQ-025 SHALL treat lim==0 in modulo mode as a hold-at-0 counter: up and down both yield q=0 with wrap set each enabled count.
REQ-026 SHALL have one-cycle latency from a qualifying edge to the new q.
REQ-027 SHALL need no extra logic for cascading: stage N+1 ent_ tied to stage N rco_, common enp_, ud and clk.

Reset
REQ-028 SHALL, on clk rising with clr=1, set q=0 and wrap=0, overriding load_ and the enables.
REQ-029 SHALL give mxmn=1/rco_=0 (with ent_=0, ud=1) or mxmn=0/rco_=1 (ud=0, top!=0) after reset, per REQ-022/023.
REQ-030 SHALL abort a pending load or count when clr is asserted mid-sequence; the next edge with clr=0 resumes normal operation from q=0.

Verification (WIDTH=4)
REQ-031 SHALL verify binary wrap: MODULO_EN=0, load 13, ud=0, enables low, 4 clocks -> q=14,15,0,1; mxmn=1/rco_=0 only at q=15; wrap=1 after q=0.
REQ-032 SHALL verify modulo up: lim=9, load 7, 4 up clocks -> q=8,9,0,1; mxmn=1 at q=9; then ud=1, 2 clocks -> q=0, then 9 with wrap set.
REQ-033 SHALL verify enable split: q=15 top, ent_=0 enp_=1 -> q holds, rco_=0; ent_=1 enp_=0 -> q holds, rco_=1.
REQ-034 SHALL verify priority: clr=1 with load_=0, in=5 -> q=0, wrap=0; next load_=0 with enables low -> q=5, wrap=0.
REQ-035 SHALL verify out-of-range: lim=9, load 12, up -> q=0 with wrap=1; reload 12, down -> q=11, mxmn=0.
REQ-036 SHALL verify a two-stage cascade (8-bit total) counting from 0x0E up 3 clocks -> 0x0F, 0x10, 0x11; low-stage rco_ low only at 0x0F.
